hub75_scan: RTL and testbench

HUB75_SCAN -- requirements
Module: hub75_scan

---
 rtl/hub75_pkg.sv | 17 +
 rtl/hub75_scan_bcm_timer.sv | 18 +
 rtl/hub75_scan.sv | 168 ++++++++++++++++
 tb/tb_hub75_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: scan FSM states, row-change dead time and port width helpers
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DEAD, SHOW} state_t;
  localparam int DEADTIME = 4;
  function automatic int addr_w(input int rows, input int cols);
    return rows * cols > 1 ? $clog2(rows * cols) : 1;
  endfunction
  function automatic int bit_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int row_w(input int rows);
    return rows > 2 ? $clog2(rows / 2) : 1;
  endfunction
  function automatic int tick_w(input int base, input int depth);
    return $clog2((base << (depth - 1)) + 1);
  endfunction
endpackage

// File: rtl/hub75_scan_bcm_timer.sv
// bcm_timer: loadable down-counter flagging the last cycle of a bit-plane display period
module bcm_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  // count down from the loaded period and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == W'(1);
endmodule

// File: rtl/hub75_scan.sv
// hub75_scan: HUB75 panel scan engine with binary-coded-modulation bit planes; define HUB75_SCAN_DEADTIME_EN to blank after row changes
module hub75_scan import hub75_pkg::*; #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int BASE_TICKS     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     ctrl_en,
  input  logic [CTRL_REG_WIDTH-1:0]                ctrl_bitdepth,
  input  logic                                     buf_sel,
  output logic                                     r_en,
  output logic                                     r_buffer,
  output logic [addr_w(N_ROWS_MAX, N_COLS_MAX)-1:0] r_addr,
  output logic [bit_w(BITDEPTH_MAX)-1:0]           r_bit,
  input  logic [5:0]                               r_dout,
  output logic [5:0]                               hub_rgb,
  output logic                                     hub_clk,
  output logic                                     hub_lat,
  output logic                                     hub_oe_n,
  output logic [row_w(N_ROWS_MAX)-1:0]             hub_addr,
  output logic                                     frame_done
);
  localparam int AW = addr_w(N_ROWS_MAX, N_COLS_MAX);
  localparam int BW = bit_w(BITDEPTH_MAX);
  localparam int RW = row_w(N_ROWS_MAX);
  localparam int SW = $clog2(2 * N_COLS_MAX + 1);
  localparam int TW = tick_w(BASE_TICKS, BITDEPTH_MAX);
  state_t state;
  logic armed, load, last_plane, last_row, tmr_load, tmr_done;
  logic [RW-1:0] row, row_n;
  logic [BW-1:0] plane, plane_n, lo, lo_n;
  logic [SW-1:0] sc, s1;
  logic [CTRL_REG_WIDTH-1:0] nb;
  logic [5:0] rgb_q;
  logic [TW-1:0] tmr_val;
`ifdef HUB75_SCAN_DEADTIME_EN
  localparam int DW = $clog2(DEADTIME);
  logic addr_chg;
  logic [DW-1:0] dcnt;
  assign tmr_load = (state == LATCH && !addr_chg) || (state == DEAD && dcnt == DW'(DEADTIME - 1));
`else
  assign tmr_load = state == LATCH;
`endif
  assign nb = ctrl_bitdepth == '0 ? CTRL_REG_WIDTH'(1) :
              ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX) ? CTRL_REG_WIDTH'(BITDEPTH_MAX) : ctrl_bitdepth;
  assign lo_n = BW'(CTRL_REG_WIDTH'(BITDEPTH_MAX) - nb);
  assign s1 = sc + SW'(1);
  assign last_plane = plane == BW'(BITDEPTH_MAX - 1);
  assign last_row = row == RW'(N_ROWS_MAX / 2 - 1);
  assign plane_n = last_plane ? lo : plane + BW'(1);
  assign row_n = last_plane ? row + RW'(1) : row;
  assign tmr_val = TW'(BASE_TICKS) << (plane - lo);
  // the read returns in the hub_clk-low cycle, so pass it straight through then and hold it after
  assign hub_rgb = load ? r_dout : rgb_q;
  bcm_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .val  (tmr_val),
    .done (tmr_done)
  );
  // scan sequencer; each transition also sets the registered outputs of the cycle it enters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      row <= '0;
      plane <= '0;
      lo <= '0;
      sc <= '0;
      load <= 1'b0;
      rgb_q <= '0;
      r_en <= 1'b0;
      r_buffer <= 1'b0;
      r_addr <= '0;
      r_bit <= '0;
      hub_clk <= 1'b0;
      hub_lat <= 1'b0;
      hub_oe_n <= 1'b1;
      hub_addr <= '0;
      frame_done <= 1'b0;
`ifdef HUB75_SCAN_DEADTIME_EN
      addr_chg <= 1'b0;
      dcnt <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (load) rgb_q <= r_dout;
      case (state)
        IDLE:
          if (!ctrl_en) armed <= 1'b0;
          else if (!armed) begin
            armed <= 1'b1;
            r_buffer <= buf_sel;
            lo <= lo_n;
            plane <= lo_n;
            row <= '0;
          end else begin
            armed <= 1'b0;
            state <= SHIFT;
            sc <= '0;
            r_en <= 1'b1;
            r_addr <= '0;
            r_bit <= plane;
          end
        SHIFT:
          if (sc == SW'(2 * N_COLS_MAX)) begin
            state <= LATCH;
            hub_clk <= 1'b0;
            hub_lat <= 1'b1;
            hub_addr <= row;
            r_en <= 1'b0;
            load <= 1'b0;
`ifdef HUB75_SCAN_DEADTIME_EN
            addr_chg <= hub_addr != row;
`endif
          end else begin
            sc <= s1;
            hub_clk <= ~s1[0];
            load <= s1[0];
            r_en <= !s1[0] && (s1 >> 1) != SW'(N_COLS_MAX);
            r_addr <= AW'(row) * AW'(N_COLS_MAX) + AW'(s1 >> 1);
          end
        LATCH: begin
          hub_lat <= 1'b0;
`ifdef HUB75_SCAN_DEADTIME_EN
          if (addr_chg) begin
            state <= DEAD;
            dcnt <= '0;
          end else begin
            state <= SHOW;
            hub_oe_n <= 1'b0;
          end
`else
          state <= SHOW;
          hub_oe_n <= 1'b0;
`endif
        end
`ifdef HUB75_SCAN_DEADTIME_EN
        DEAD:
          if (dcnt == DW'(DEADTIME - 1)) begin
            state <= SHOW;
            hub_oe_n <= 1'b0;
          end else dcnt <= dcnt + DW'(1);
`endif
        SHOW:
          if (tmr_done) begin
            hub_oe_n <= 1'b1;
            plane <= plane_n;
            row <= last_plane && last_row ? '0 : row_n;
            if (last_plane && last_row) begin
              state <= IDLE;
              frame_done <= 1'b1;
            end else begin
              state <= SHIFT;
              sc <= '0;
              r_en <= 1'b1;
              r_addr <= AW'(row_n) * AW'(N_COLS_MAX);
              r_bit <= plane_n;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: directed checks of shift timing, plane lengths, bit-depth clamping, frame boundaries and reset
module tb_hub75_scan;
  localparam int NR = 64, NC = 4, BD = 8, CW = 32, BT = 16;
`ifdef HUB75_SCAN_DEADTIME_EN
  localparam int DT = 4;
`else
  localparam int DT = 0;
`endif
  logic clk = 0, rst_n = 0, ctrl_en = 0, buf_sel = 0;
  logic [CW-1:0] ctrl_bitdepth = '0;
  logic r_en, r_buffer;
  logic [7:0] r_addr;
  logic [2:0] r_bit;
  logic [5:0] r_dout = '0;
  logic [5:0] hub_rgb;
  logic hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [4:0] hub_addr;
  int checks = 0, errors = 0;

  hub75_scan #(.N_ROWS_MAX(NR), .N_COLS_MAX(NC), .BITDEPTH_MAX(BD), .CTRL_REG_WIDTH(CW), .BASE_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .ctrl_bitdepth(ctrl_bitdepth), .buf_sel(buf_sel),
    .r_en(r_en), .r_buffer(r_buffer), .r_addr(r_addr), .r_bit(r_bit), .r_dout(r_dout),
    .hub_rgb(hub_rgb), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // framebuffer: one-cycle read returning {buffer, plane, column}
  always @(posedge clk) if (r_en) r_dout <= {r_buffer, r_bit, r_addr[1:0]};

  task automatic start(input logic [CW-1:0] bd, input logic bs);
    rst_n = 0; ctrl_en = 0; ctrl_bitdepth = bd; buf_sel = bs;
    repeat (2) @(negedge clk);
    rst_n = 1; ctrl_en = 1;
  endtask

  task automatic wait_lat(output int gap, output bit ok);
    int n = 0;
    ok = 0; gap = -1;
    do begin @(negedge clk); n++; end while (hub_lat !== 1'b1 && n < 6000);
    if (hub_lat !== 1'b1) return;
    n = 0;
    do begin @(negedge clk); n++; end while (hub_oe_n !== 1'b0 && n < 20);
    gap = n - 1; ok = hub_oe_n === 1'b0;
  endtask

  task automatic show_len(output int len);
    len = 1;
    while (len < 5000) begin
      @(negedge clk);
      if (hub_oe_n !== 1'b0) break;
      len++;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; ctrl_en = 1; ctrl_bitdepth = 8;
    repeat (3) @(negedge clk);
    checks++; if (hub_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", hub_oe_n); end
    checks++; if ({hub_clk, hub_lat, hub_rgb, hub_addr} !== '0) begin errors++; $display("FAIL reset_hub: clk %b lat %b rgb %h addr %0d want all 0", hub_clk, hub_lat, hub_rgb, hub_addr); end
    checks++; if ({r_en, r_buffer, r_addr, r_bit, frame_done} !== '0) begin errors++; $display("FAIL reset_rd: en %b buf %b addr %0d bit %0d fd %b want all 0", r_en, r_buffer, r_addr, r_bit, frame_done); end
  endtask

  task automatic test_shift;
    int n = 0, rises = 0, reads = 1;
    logic pclk;
    bit seen_oe = 0;
    ctrl_bitdepth = 8; buf_sel = 1; ctrl_en = 1; rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL start_edge1: r_en %b want 0", r_en); end
    @(negedge clk);
    checks++; if (r_en !== 1'b1 || r_addr !== 8'd0 || r_bit !== 3'd0) begin errors++; $display("FAIL start_edge2: r_en %b addr %0d bit %0d want 1 0 0", r_en, r_addr, r_bit); end
    pclk = hub_clk;
    while (hub_lat !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (hub_oe_n !== 1'b1) seen_oe = 1;
      if (r_en === 1'b1) reads++;
      if (hub_clk === 1'b1 && pclk === 1'b0) begin
        checks++; if (hub_rgb !== {1'b1, 3'd0, 2'(rises)}) begin errors++; $display("FAIL col_rgb %0d: got %h want %h", rises, hub_rgb, {1'b1, 3'd0, 2'(rises)}); end
        rises++;
      end
      pclk = hub_clk;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL shift_len: got %0d want 9", n); end
    checks++; if (rises != 4) begin errors++; $display("FAIL hub_clk_rises: got %0d want 4", rises); end
    checks++; if (reads != 4) begin errors++; $display("FAIL read_count: got %0d want 4", reads); end
    checks++; if (seen_oe) begin errors++; $display("FAIL oe_in_shift: got low want high"); end
    checks++; if (hub_addr !== 5'd0) begin errors++; $display("FAIL lat_addr0: got %0d want 0", hub_addr); end
  endtask

  task automatic test_show_lengths;
    int gap, len;
    bit ok;
    start(8, 0);
    for (int p = 0; p < 8; p++) begin
      wait_lat(gap, ok);
      if (ok) show_len(len); else len = -1;
      checks++; if (len != (BT << p)) begin errors++; $display("FAIL show_len plane %0d: got %0d want %0d", p, len, BT << p); end
      checks++; if (gap != 0) begin errors++; $display("FAIL same_row_gap plane %0d: got %0d want 0", p, gap); end
    end
    wait_lat(gap, ok);
    checks++; if (!ok || hub_addr !== 5'd1) begin errors++; $display("FAIL row_advance: ok %0d addr %0d want 1", ok, hub_addr); end
    checks++; if (gap != DT) begin errors++; $display("FAIL row_change_gap: got %0d want %0d", gap, DT); end
  endtask

  task automatic test_reset_in_show;
    int gap;
    bit ok;
    #1 rst_n = 0;
    #1;
    checks++; if (hub_oe_n !== 1'b1 || hub_addr !== 5'd0) begin errors++; $display("FAIL async_reset: oe_n %b addr %0d want 1 0", hub_oe_n, hub_addr); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL restart_edge1: r_en %b want 0", r_en); end
    @(negedge clk);
    checks++; if (r_en !== 1'b1 || r_addr !== 8'd0 || r_bit !== 3'd0) begin errors++; $display("FAIL restart: r_en %b addr %0d bit %0d want 1 0 0", r_en, r_addr, r_bit); end
    wait_lat(gap, ok);
    checks++; if (!ok || hub_addr !== 5'd0 || gap != 0) begin errors++; $display("FAIL restart_row: ok %0d addr %0d gap %0d want 1 0 0", ok, hub_addr, gap); end
  endtask

  task automatic test_bitdepth;
    int gap, len;
    bit ok;
    start(0, 0);
    repeat (2) @(negedge clk);
    checks++; if (r_en !== 1'b1 || r_bit !== 3'd7) begin errors++; $display("FAIL bd0_plane: r_en %b bit %0d want 1 7", r_en, r_bit); end
    wait_lat(gap, ok);
    if (ok) show_len(len); else len = -1;
    checks++; if (len != 16) begin errors++; $display("FAIL bd0_show: got %0d want 16", len); end
    wait_lat(gap, ok);
    checks++; if (!ok || hub_addr !== 5'd1) begin errors++; $display("FAIL bd0_row: ok %0d addr %0d want 1", ok, hub_addr); end
    show_len(len);
    checks++; if (len != 16) begin errors++; $display("FAIL bd0_show2: got %0d want 16", len); end
    start(12, 0);
    repeat (2) @(negedge clk);
    checks++; if (r_en !== 1'b1 || r_bit !== 3'd0) begin errors++; $display("FAIL bd12_plane: r_en %b bit %0d want 1 0", r_en, r_bit); end
    wait_lat(gap, ok);
    if (ok) show_len(len); else len = -1;
    checks++; if (len != 16) begin errors++; $display("FAIL bd12_show0: got %0d want 16", len); end
    wait_lat(gap, ok);
    if (ok) show_len(len); else len = -1;
    checks++; if (len != 32 || hub_addr !== 5'd0) begin errors++; $display("FAIL bd12_show1: len %0d addr %0d want 32 0", len, hub_addr); end
  endtask

  task automatic test_frame;
    int cyc = 0, lats = 0, last_addr = -1, n = 0, active = 0;
    bit early_buf = 0;
    start(1, 0);
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (cyc == 300) begin buf_sel = 1; ctrl_bitdepth = 8; end
      if (cyc == 600) ctrl_bitdepth = 1;
      if (hub_lat === 1'b1) begin lats++; last_addr = int'(hub_addr); end
      if (frame_done === 1'b1) break;
      if (r_buffer !== 1'b0) early_buf = 1;
    end
    checks++; if (frame_done !== 1'b1 || cyc != 834) begin errors++; $display("FAIL frame_len: done %b at %0d want 1 at 834", frame_done, cyc); end
    checks++; if (lats != 32 || last_addr != 31) begin errors++; $display("FAIL frame_rows: lats %0d last %0d want 32 31", lats, last_addr); end
    checks++; if (early_buf) begin errors++; $display("FAIL buf_mid_frame: changed want held"); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0 || r_buffer !== 1'b1) begin errors++; $display("FAIL frame_edge: fd %b buf %b want 0 1", frame_done, r_buffer); end
    while (n < 20 && hub_clk !== 1'b1) begin @(negedge clk); n++; end
    checks++; if (hub_rgb !== 6'b111100) begin errors++; $display("FAIL new_buf_rgb: got %b want 111100", hub_rgb); end
    repeat (100) @(negedge clk);
    ctrl_en = 0;
    n = 0;
    while (n < 2000 && frame_done !== 1'b1) begin @(negedge clk); n++; end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stop_completes: no frame_done after %0d cycles", n); end
    repeat (200) begin
      @(negedge clk);
      if (r_en !== 1'b0 || hub_oe_n !== 1'b1) active++;
    end
    checks++; if (active != 0) begin errors++; $display("FAIL stays_idle: %0d active cycles want 0", active); end
  endtask

  initial begin
    test_reset;
    test_shift;
    test_show_lengths;
    test_reset_in_show;
    test_bitdepth;
    test_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
